// File: rtl/control_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : control_unit_if                                           |
// | Purpose  : Controller <-> datapath bundle for the MP-8 processor:    |
// |            opcode/status in, control strobes and debug state out.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface control_unit_if #(
  parameter int ICNT_W = 16
);
  // Datapath / environment -> controller
  logic [2:0]        opcode;
  logic              zero;
  logic              pos;
  logic              in_valid;
  // Controller -> datapath / environment
  logic              in_ack;
  logic              out_valid;
  logic              PCWrite;
  logic              IorD;
  logic              PCSrc;
  logic              IRWrite;
  logic              AccWrite;
  logic              OutWrite;
  logic [1:0]        AccSrc;
  logic [1:0]        ALUControl;
  logic              halted;
  logic [2:0]        state;
  logic [ICNT_W-1:0] icount;

  // The controller is the master: it owns every strobe.
  modport master (
    input  opcode, zero, pos, in_valid,
    output in_ack, out_valid, PCWrite, IorD, PCSrc, IRWrite, AccWrite,
           OutWrite, AccSrc, ALUControl, halted, state, icount
  );

  // The datapath/environment side.
  modport slave (
    output opcode, zero, pos, in_valid,
    input  in_ack, out_valid, PCWrite, IorD, PCSrc, IRWrite, AccWrite,
           OutWrite, AccSrc, ALUControl, halted, state, icount
  );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : control_unit                                              |
// | Purpose  : Multicycle FSM controller for the MP-8 processor.         |
// |            FETCH -> DECODE -> EXEC, WAIT_IN input handshake, HALT,   |
// |            saturating retired-instruction counter.                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module control_unit #(
  parameter int ICNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,   // asynchronous, active-low
  control_unit_if.master        dp_io
);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_IN = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_IN   = 3'b011;
  localparam logic [2:0] OP_JZ   = 3'b100;
  localparam logic [2:0] OP_JPOS = 3'b101;
  localparam logic [2:0] OP_OUT  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t            state_q, state_d;
  logic [ICNT_W-1:0] icount_q, icount_d;
  logic              retire;

  logic       in_ack, out_valid, pc_write, iord, pc_src;
  logic       ir_write, acc_write, out_write, halted;
  logic [1:0] acc_src, alu_ctrl;

  // State and retired-instruction counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_START;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

  // Next-state and strobe decode; every strobe defaults low so an
  // abandoned or illegal state can never leave a write enable asserted.
  always_comb begin
    state_d   = S_START;
    retire    = 1'b0;
    in_ack    = 1'b0;
    out_valid = 1'b0;
    pc_write  = 1'b0;
    iord      = 1'b0;
    pc_src    = 1'b0;
    ir_write  = 1'b0;
    acc_write = 1'b0;
    out_write = 1'b0;
    acc_src   = 2'b00;
    alu_ctrl  = 2'b00;
    halted    = 1'b0;

    case (state_q)
      S_START: state_d = S_FETCH;

      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;        // PC <= PC + 1 (PCSrc = 0)
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        iord = 1'b1;            // memory now addresses IR[4:0]
        if (dp_io.opcode == OP_IN) begin
          state_d = S_WAIT_IN;
        end else if (dp_io.opcode == OP_HALT) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        iord    = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
        case (dp_io.opcode)
          OP_LOAD: begin
            acc_src   = 2'b01;
            acc_write = 1'b1;
          end
          OP_ADD: begin
            acc_src   = 2'b00;
            alu_ctrl  = 2'b00;
            acc_write = 1'b1;
          end
          OP_SUB: begin
            acc_src   = 2'b00;
            alu_ctrl  = 2'b01;
            acc_write = 1'b1;
          end
          // Jumps use the flags of the Acc value before this instruction.
          OP_JZ: begin
            pc_src   = 1'b1;
            pc_write = dp_io.zero;
          end
          OP_JPOS: begin
            pc_src   = 1'b1;
            pc_write = dp_io.pos;
          end
          OP_OUT: begin
            out_write = 1'b1;
            out_valid = 1'b1;
          end
          default: ;            // IN/HALT never reach EXEC
        endcase
      end

      S_WAIT_IN: begin
        if (dp_io.in_valid) begin
          acc_src   = 2'b10;
          acc_write = 1'b1;
          in_ack    = 1'b1;
          state_d   = S_FETCH;
          retire    = 1'b1;
        end else begin
          state_d = S_WAIT_IN;
        end
      end

      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end

      default: state_d = S_START;  // codes 6/7 recover via START
    endcase
  end

  // Saturating counter update.
  always_comb begin
    icount_d = icount_q;
    if (retire && (icount_q != '1)) begin
      icount_d = icount_q + 1'b1;
    end
  end

  assign dp_io.in_ack     = in_ack;
  assign dp_io.out_valid  = out_valid;
  assign dp_io.PCWrite    = pc_write;
  assign dp_io.IorD       = iord;
  assign dp_io.PCSrc      = pc_src;
  assign dp_io.IRWrite    = ir_write;
  assign dp_io.AccWrite   = acc_write;
  assign dp_io.OutWrite   = out_write;
  assign dp_io.AccSrc     = acc_src;
  assign dp_io.ALUControl = alu_ctrl;
  assign dp_io.halted     = halted;
  assign dp_io.state      = state_q;
  assign dp_io.icount     = icount_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_control_unit                                           |
// | Purpose  : Self-checking bench for control_unit: per-cycle vector    |
// |            table over a full program plus HALT/reset/saturation.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_control_unit;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_IN   = 3'b011;
  localparam logic [2:0] OP_JZ   = 3'b100;
  localparam logic [2:0] OP_JPOS = 3'b101;
  localparam logic [2:0] OP_OUT  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [2:0] ST_START = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DEC   = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  // Strobe bundle: {in_ack, out_valid, PCWrite, IorD, PCSrc, IRWrite,
  //                 AccWrite, OutWrite, AccSrc[1:0], ALUControl[1:0], halted}
  localparam logic [12:0] K_NONE  = 13'b0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [12:0] K_FETCH = 13'b0_0_1_0_0_1_0_0_00_00_0;
  localparam logic [12:0] K_DEC   = 13'b0_0_0_1_0_0_0_0_00_00_0;
  localparam logic [12:0] K_LOAD  = 13'b0_0_0_1_0_0_1_0_01_00_0;
  localparam logic [12:0] K_ADD   = 13'b0_0_0_1_0_0_1_0_00_00_0;
  localparam logic [12:0] K_SUB   = 13'b0_0_0_1_0_0_1_0_00_01_0;
  localparam logic [12:0] K_JTAKE = 13'b0_0_1_1_1_0_0_0_00_00_0;
  localparam logic [12:0] K_JNOT  = 13'b0_0_0_1_1_0_0_0_00_00_0;
  localparam logic [12:0] K_OUT   = 13'b0_1_0_1_0_0_0_1_00_00_0;
  localparam logic [12:0] K_INACK = 13'b1_0_0_0_0_0_1_0_10_00_0;
  localparam logic [12:0] K_HALT  = 13'b0_0_0_0_0_0_0_0_00_00_1;

  typedef struct packed {
    logic [2:0]  op;
    logic        z;
    logic        p;
    logic        iv;
    logic [2:0]  st;
    logic [12:0] strb;
    logic [15:0] ic;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vq[$];

  control_unit_if #(.ICNT_W(16)) cu_if ();
  control_unit_if #(.ICNT_W(2))  sat_if ();

  control_unit #(.ICNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .dp_io (cu_if.master)
  );

  // Narrow-counter instance running LOAD forever to exercise saturation.
  control_unit #(.ICNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .dp_io (sat_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] strobes();
    return {cu_if.in_ack, cu_if.out_valid, cu_if.PCWrite, cu_if.IorD,
            cu_if.PCSrc, cu_if.IRWrite, cu_if.AccWrite, cu_if.OutWrite,
            cu_if.AccSrc, cu_if.ALUControl, cu_if.halted};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic z, input logic p,
                     input logic iv, input logic [2:0] st,
                     input logic [12:0] strb, input logic [15:0] ic);
    vec_t v;
    v.op = op; v.z = z; v.p = p; v.iv = iv;
    v.st = st; v.strb = strb; v.ic = ic;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [2:0] op, input logic z, input logic p,
                       input logic iv);
    cu_if.opcode   = op;
    cu_if.zero     = z;
    cu_if.pos      = p;
    cu_if.in_valid = iv;
  endtask

  initial begin
    // Program: LOAD, ADD, SUB, JZ(z=1), JZ(z=0), JPOS(p=1), JPOS(p=0),
    // IN (4 idle cycles), OUT, HALT.  Row k = k-th cycle after reset release.
    add(OP_LOAD, 0, 0, 0, ST_START, K_NONE,  0);
    add(OP_LOAD, 0, 0, 0, ST_FETCH, K_FETCH, 0);
    add(OP_LOAD, 0, 0, 0, ST_DEC,   K_DEC,   0);
    add(OP_LOAD, 0, 0, 0, ST_EXEC,  K_LOAD,  0);
    add(OP_ADD,  0, 1, 0, ST_FETCH, K_FETCH, 1);
    add(OP_ADD,  0, 1, 0, ST_DEC,   K_DEC,   1);
    add(OP_ADD,  0, 1, 0, ST_EXEC,  K_ADD,   1);
    add(OP_SUB,  0, 1, 0, ST_FETCH, K_FETCH, 2);
    add(OP_SUB,  0, 1, 0, ST_DEC,   K_DEC,   2);
    add(OP_SUB,  0, 1, 0, ST_EXEC,  K_SUB,   2);
    add(OP_JZ,   1, 0, 0, ST_FETCH, K_FETCH, 3);
    add(OP_JZ,   1, 0, 0, ST_DEC,   K_DEC,   3);
    add(OP_JZ,   1, 0, 0, ST_EXEC,  K_JTAKE, 3);
    add(OP_JZ,   0, 1, 0, ST_FETCH, K_FETCH, 4);
    add(OP_JZ,   0, 1, 0, ST_DEC,   K_DEC,   4);
    add(OP_JZ,   0, 1, 0, ST_EXEC,  K_JNOT,  4);
    add(OP_JPOS, 0, 1, 0, ST_FETCH, K_FETCH, 5);
    add(OP_JPOS, 0, 1, 0, ST_DEC,   K_DEC,   5);
    add(OP_JPOS, 0, 1, 0, ST_EXEC,  K_JTAKE, 5);
    add(OP_JPOS, 1, 0, 0, ST_FETCH, K_FETCH, 6);
    add(OP_JPOS, 1, 0, 0, ST_DEC,   K_DEC,   6);
    add(OP_JPOS, 1, 0, 0, ST_EXEC,  K_JNOT,  6);
    add(OP_IN,   0, 0, 0, ST_FETCH, K_FETCH, 7);
    add(OP_IN,   0, 0, 0, ST_DEC,   K_DEC,   7);
    for (int k = 0; k < 4; k++) add(OP_IN, 0, 0, 0, ST_WAIT, K_NONE, 7);
    add(OP_IN,   0, 0, 1, ST_WAIT,  K_INACK, 7);
    add(OP_OUT,  0, 0, 0, ST_FETCH, K_FETCH, 8);
    add(OP_OUT,  0, 0, 0, ST_DEC,   K_DEC,   8);
    add(OP_OUT,  0, 0, 0, ST_EXEC,  K_OUT,   8);
    add(OP_HALT, 0, 0, 0, ST_FETCH, K_FETCH, 9);
    add(OP_HALT, 0, 0, 0, ST_DEC,   K_DEC,   9);
    add(OP_HALT, 0, 0, 0, ST_HALT,  K_HALT,  10);

    sat_if.opcode   = OP_LOAD;
    sat_if.zero     = 1'b0;
    sat_if.pos      = 1'b0;
    sat_if.in_valid = 1'b0;
    drive(OP_ADD, 1'b1, 1'b1, 1'b1);

    // Reset held: outputs must already be zero.
    #1;
    check("reset_state",  32'(cu_if.state),  32'(ST_START));
    check("reset_strobe", 32'(strobes()),    32'(K_NONE));
    check("reset_icount", 32'(cu_if.icount), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_state", 32'(cu_if.state), 32'(ST_START));

    // Release and walk the vector table, one row per cycle.
    reset = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].op, vq[i].z, vq[i].p, vq[i].iv);
      @(negedge clk);
      check($sformatf("row%0d_state", i),  32'(cu_if.state),  32'(vq[i].st));
      check($sformatf("row%0d_strobe", i), 32'(strobes()),    32'(vq[i].strb));
      check($sformatf("row%0d_icount", i), 32'(cu_if.icount), 32'(vq[i].ic));
      if (i == 7)  check("sat_icount_2", 32'(sat_if.icount), 32'd2);
      if (i == 34) check("sat_icount_held", 32'(sat_if.icount), 32'd3);
      @(posedge clk);
      #1;
    end

    // HALT is terminal: in_valid and flags toggling must not matter.
    for (int k = 0; k < 20; k++) begin
      drive(3'(k), k[0], k[1], ~k[0]);
      @(negedge clk);
      check($sformatf("halt%0d_state", k),  32'(cu_if.state),  32'(ST_HALT));
      check($sformatf("halt%0d_strobe", k), 32'(strobes()),    32'(K_HALT));
      check($sformatf("halt%0d_icount", k), 32'(cu_if.icount), 32'd10);
      @(posedge clk);
      #1;
    end

    // Restart, run to EXEC of ADD, then abort it with an async reset.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(OP_ADD, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst2_start", 32'(cu_if.state), 32'(ST_START));
    repeat (3) @(posedge clk);
    #2;
    check("rst2_exec_state",  32'(cu_if.state), 32'(ST_EXEC));
    check("rst2_exec_strobe", 32'(strobes()),   32'(K_ADD));
    check("rst2_exec_icount", 32'(cu_if.icount), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_state",  32'(cu_if.state),  32'(ST_START));
    check("midrst_strobe", 32'(strobes()),    32'(K_NONE));
    check("midrst_icount", 32'(cu_if.icount), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_hold_state",  32'(cu_if.state),  32'(ST_START));
    check("midrst_hold_icount", 32'(cu_if.icount), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("resume_start", 32'(cu_if.state), 32'(ST_START));
    @(negedge clk);
    check("resume_fetch_state",  32'(cu_if.state), 32'(ST_FETCH));
    check("resume_fetch_strobe", 32'(strobes()),   32'(K_FETCH));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
